// File: rtl/usb_spi_flash_arb.sv
// usb_spi_flash_arb
//
// Shares one SPI flash pin set between two masters. Port 0 is the DFU control endpoint's
// flash bridge; port 1 is a secondary master (boot-image or flash-ID reader). Whole
// transactions are granted: an owner keeps the pins until it has both dropped its request
// and raised its chip select. A chip-select-high guard period separates owners, and an
// optional hold timeout revokes a grant that is held too long.
//
// Parameters:
//   GUARD_CYCLES  cycles spi_csel_o is forced high after a release/revoke (1..255)
//   HOLD_TIMEOUT  max cycles a grant may be held; 0 disables the timeout
//
// Ports:
//   clk_i        system clock (shared with the USB endpoint logic)
//   reset_ni     synchronous reset, active low
//   req_i[1:0]   per-port request
//   grant_o[1:0] registered grant, one-hot or zero
//   m_csel_i     per-port chip select (active low)
//   m_clk_i      per-port SPI clock
//   m_mosi_i     per-port MOSI
//   m_miso_o     per-port MISO, only the granted port sees spi_miso_i
//   spi_csel_o   flash chip select
//   spi_clk_o    flash SPI clock
//   spi_mosi_o   flash MOSI
//   spi_miso_i   flash MISO
//   busy_o       high while a port owns the pins or the guard period runs
//   timeout_o    one-cycle pulse when a grant is revoked by the hold timeout

module usb_spi_flash_arb #(
  parameter int unsigned GUARD_CYCLES = 4,
  parameter int unsigned HOLD_TIMEOUT = 0
) (
  input  logic       clk_i,
  input  logic       reset_ni,
  input  logic [1:0] req_i,
  output logic [1:0] grant_o,
  input  logic [1:0] m_csel_i,
  input  logic [1:0] m_clk_i,
  input  logic [1:0] m_mosi_i,
  output logic [1:0] m_miso_o,
  output logic       spi_csel_o,
  output logic       spi_clk_o,
  output logic       spi_mosi_o,
  input  logic       spi_miso_i,
  output logic       busy_o,
  output logic       timeout_o
);

  localparam logic [7:0]  GuardLoad = 8'(GUARD_CYCLES - 1);
  localparam logic [31:0] HoldLast  = 32'(HOLD_TIMEOUT - 1);
  localparam bit          HoldEn    = (HOLD_TIMEOUT != 0);

  typedef enum logic [1:0] {
    StIdle,
    StGrant,
    StGuard
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  grant_q, grant_d;
  logic        last_q, last_d;
  logic [7:0]  guard_cnt_q, guard_cnt_d;
  logic [31:0] hold_cnt_q, hold_cnt_d;
  logic        timeout_q, timeout_d;

  // Index of the current owner; only meaningful in StGrant where grant_q is one-hot.
  logic own;
  logic pick;
  logic release_ok;

  assign own        = grant_q[1];
  // Release needs both a dropped request and a raised chip select, so a command in
  // flight is never cut short.
  assign release_ok = ~req_i[own] & m_csel_i[own];

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    last_d      = last_q;
    guard_cnt_d = guard_cnt_q;
    hold_cnt_d  = hold_cnt_q;
    timeout_d   = 1'b0;
    pick        = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (req_i != 2'b00) begin
          // Tie goes to the port that did not own last.
          pick        = (req_i == 2'b11) ? ~last_q : req_i[1];
          grant_d     = pick ? 2'b10 : 2'b01;
          last_d      = pick;
          hold_cnt_d  = '0;
          state_d     = StGrant;
        end
      end
      StGrant: begin
        if (release_ok) begin
          // Release wins over a coincident timeout.
          grant_d     = 2'b00;
          guard_cnt_d = GuardLoad;
          state_d     = StGuard;
        end else if (HoldEn && (hold_cnt_q == HoldLast)) begin
          grant_d     = 2'b00;
          guard_cnt_d = GuardLoad;
          timeout_d   = 1'b1;
          state_d     = StGuard;
        end else if (HoldEn) begin
          hold_cnt_d  = hold_cnt_q + 32'd1;
        end
      end
      StGuard: begin
        if (guard_cnt_q == 8'd0) begin
          state_d     = StIdle;
        end else begin
          guard_cnt_d = guard_cnt_q - 8'd1;
        end
      end
      default: begin
        state_d = StIdle;
        grant_d = 2'b00;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_q     <= StIdle;
      grant_q     <= 2'b00;
      last_q      <= 1'b1;
      guard_cnt_q <= '0;
      hold_cnt_q  <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      last_q      <= last_d;
      guard_cnt_q <= guard_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      timeout_q   <= timeout_d;
    end
  end

  // Pin mux: combinational pass-through from the owner, idle values otherwise.
  always_comb begin
    spi_csel_o = 1'b1;
    spi_clk_o  = 1'b0;
    spi_mosi_o = 1'b0;
    m_miso_o   = 2'b00;
    if (state_q == StGrant) begin
      spi_csel_o = m_csel_i[own];
      spi_clk_o  = m_clk_i[own];
      spi_mosi_o = m_mosi_i[own];
      m_miso_o   = own ? {spi_miso_i, 1'b0} : {1'b0, spi_miso_i};
    end
  end

  assign grant_o   = grant_q;
  assign busy_o    = (state_q != StIdle);
  assign timeout_o = timeout_q;

  // Invariants.
  a_grant_onehot0 : assert property (@(posedge clk_i) disable iff (!reset_ni)
                                     grant_o != 2'b11);
  a_csel_idle     : assert property (@(posedge clk_i) disable iff (!reset_ni)
                                     (grant_o == 2'b00) |-> spi_csel_o);

endmodule

// File: tb/tb_usb_spi_flash_arb.sv
// Testbench for usb_spi_flash_arb: directed phases with randomized SPI data lines and a
// final random phase, all checked every cycle against a transaction-level owner model.

module tb_usb_spi_flash_arb;

  localparam int GUARD = 4;
  localparam int HOLD  = 100;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [1:0] req = 2'b11;
  logic [1:0] m_csel = 2'b11;
  logic [1:0] m_clk = 2'b00;
  logic [1:0] m_mosi = 2'b00;
  logic       spi_miso = 1'b0;
  logic [1:0] grant_o;
  logic [1:0] m_miso_o;
  logic       spi_csel_o, spi_clk_o, spi_mosi_o, busy_o, timeout_o;

  usb_spi_flash_arb #(
    .GUARD_CYCLES(GUARD),
    .HOLD_TIMEOUT(HOLD)
  ) dut (
    .clk_i     (clk),
    .reset_ni  (reset_n),
    .req_i     (req),
    .grant_o   (grant_o),
    .m_csel_i  (m_csel),
    .m_clk_i   (m_clk),
    .m_mosi_i  (m_mosi),
    .m_miso_o  (m_miso_o),
    .spi_csel_o(spi_csel_o),
    .spi_clk_o (spi_clk_o),
    .spi_mosi_o(spi_mosi_o),
    .spi_miso_i(spi_miso),
    .busy_o    (busy_o),
    .timeout_o (timeout_o)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: who owns the flash, how many csel-high cycles remain before
  // arbitration is allowed, who owned last, and how long the owner has held.
  int mo_owner = -1;
  int mo_guard = 0;
  int mo_last  = 1;
  int mo_held  = 0;
  bit mo_to    = 1'b0;

  function automatic void model_edge();
    if (!reset_n) begin
      mo_owner = -1;
      mo_guard = 0;
      mo_last  = 1;
      mo_held  = 0;
      mo_to    = 1'b0;
    end else begin
      mo_to = 1'b0;
      if (mo_owner >= 0) begin
        mo_held++;
        if (!req[mo_owner] && m_csel[mo_owner]) begin
          mo_owner = -1;
          mo_guard = GUARD;
        end else if (HOLD > 0 && mo_held >= HOLD) begin
          mo_owner = -1;
          mo_guard = GUARD;
          mo_to    = 1'b1;
        end
      end else if (mo_guard > 0) begin
        mo_guard--;
      end else if (req != 2'b00) begin
        mo_owner = (req == 2'b11) ? 1 - mo_last : (req[1] ? 1 : 0);
        mo_last  = mo_owner;
        mo_held  = 0;
      end
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    logic [1:0] eg, emiso;
    logic       ecs, eclk, emosi;
    if (mo_owner < 0) begin
      eg = 2'b00; ecs = 1'b1; eclk = 1'b0; emosi = 1'b0; emiso = 2'b00;
    end else begin
      eg    = (mo_owner == 1) ? 2'b10 : 2'b01;
      ecs   = m_csel[mo_owner];
      eclk  = m_clk[mo_owner];
      emosi = m_mosi[mo_owner];
      emiso = (mo_owner == 1) ? {spi_miso, 1'b0} : {1'b0, spi_miso};
    end
    chk("grant", 32'(grant_o), 32'(eg));
    chk("spi_csel", 32'(spi_csel_o), 32'(ecs));
    chk("spi_clk", 32'(spi_clk_o), 32'(eclk));
    chk("spi_mosi", 32'(spi_mosi_o), 32'(emosi));
    chk("m_miso", 32'(m_miso_o), 32'(emiso));
    chk("busy", 32'(busy_o), 32'((mo_owner >= 0) || (mo_guard > 0)));
    chk("timeout", 32'(timeout_o), 32'(mo_to));
  endtask

  // One clock: model and DUT both take the edge, outputs are checked 2 time units later,
  // then the data lines get fresh random values well away from the next edge.
  task automatic cycle();
    @(posedge clk);
    model_edge();
    #2;
    check_all();
    m_clk    = 2'($urandom);
    m_mosi   = 2'($urandom);
    spi_miso = 1'($urandom);
  endtask

  task automatic wait_owner(input string tag);
    for (int w = 0; w < 20 && mo_owner < 0; w++) cycle();
    chk(tag, 32'(mo_owner >= 0), 32'd1);
  endtask

  logic [1:0] exp_seq [4];
  int gap, o, n_to, to_idx;

  initial begin
    exp_seq = '{2'b10, 2'b01, 2'b10, 2'b01};

    // Reset with both ports requesting.
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("rst_grant", 32'(grant_o), 32'd0);
      chk("rst_csel", 32'(spi_csel_o), 32'd1);
    end
    reset_n = 1'b1;
    cycle();
    chk("first_tie_port0", 32'(grant_o), 32'b01);

    // Single owner: port 0 runs a 16-cycle command, then releases.
    req    = 2'b01;
    m_csel = 2'b10;
    for (int i = 0; i < 16; i++) cycle();
    req    = 2'b00;
    m_csel = 2'b11;
    for (int i = 0; i < 8; i++) cycle();

    // Round robin with both ports requesting continuously.
    req = 2'b11;
    gap = 0;
    for (int k = 0; k < 4; k++) begin
      wait_owner("rr_wait");
      chk("rr_seq", 32'(grant_o), 32'(exp_seq[k]));
      if (k > 0) chk("rr_gap_ge5", 32'(gap >= GUARD + 1), 32'd1);
      o = (grant_o == 2'b10) ? 1 : 0;
      m_csel[o] = 1'b0;
      for (int i = 0; i < 10; i++) cycle();
      req[o]    = 1'b0;
      m_csel[o] = 1'b1;
      cycle();
      gap = 0;
      if (spi_csel_o === 1'b1 && grant_o === 2'b00) gap = 1;
      req = 2'b11;
      for (int w = 0; w < 20 && mo_owner < 0; w++) begin
        cycle();
        if (spi_csel_o === 1'b1 && grant_o === 2'b00) gap++;
      end
    end

    // Early request drop by port 1 while its chip select is still low.
    req = 2'b00;
    for (int i = 0; i < 8; i++) cycle();
    req = 2'b10;
    wait_owner("drop_wait");
    m_csel = 2'b01;
    for (int i = 0; i < 3; i++) cycle();
    req = 2'b00;
    for (int i = 0; i < 7; i++) begin
      cycle();
      chk("drop_hold_grant", 32'(grant_o), 32'b10);
      chk("drop_csel_low", 32'(spi_csel_o), 32'd0);
    end
    m_csel = 2'b11;
    cycle();
    chk("drop_release", 32'(grant_o), 32'd0);

    // Hold timeout: port 0 never releases, port 1 waits.
    for (int i = 0; i < 6; i++) cycle();
    req    = 2'b11;
    m_csel = 2'b10;
    wait_owner("to_wait");
    chk("to_owner0", 32'(grant_o), 32'b01);
    n_to   = 0;
    to_idx = 0;
    for (int i = 1; i <= 120; i++) begin
      cycle();
      if (timeout_o === 1'b1) begin
        n_to++;
        to_idx = i;
      end
    end
    chk("to_pulses", 32'(n_to), 32'd1);
    chk("to_cycle", 32'(to_idx), 32'(HOLD));
    chk("to_port1_after", 32'(grant_o), 32'b10);
    req    = 2'b00;
    m_csel = 2'b11;
    for (int i = 0; i < 8; i++) cycle();

    // Reset in the middle of a port 1 transaction: no guard period afterwards.
    req    = 2'b10;
    m_csel = 2'b01;
    wait_owner("mid_wait");
    for (int i = 0; i < 3; i++) cycle();
    reset_n = 1'b0;
    cycle();
    chk("mid_grant", 32'(grant_o), 32'd0);
    chk("mid_csel", 32'(spi_csel_o), 32'd1);
    chk("mid_busy", 32'(busy_o), 32'd0);
    reset_n = 1'b1;
    req     = 2'b01;
    m_csel  = 2'b11;
    cycle();
    chk("mid_regrant", 32'(grant_o), 32'b01);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(3) == 0) req = 2'($urandom);
      if ($urandom_range(2) == 0) m_csel = 2'($urandom);
      reset_n = ($urandom_range(99) != 0);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
